matrix_uart_parser: RTL and testbench

- Receive-side counterpart of the matrix UART display path: consumes ASCII bytes from the UART RX byte interface and parses them into a row-major matrix plus its dimensions.
- Input stream format: `<rows> <cols> <e0> <e1> ... <e(rows*cols-1)>`, decimal tokens separated by delimiters.
- Sits between the UART receiver and matrix storage. Top pulses `start` to arm it, then commits `data_flat`/`matrix_row`/`matrix_col` to storage on `done`.

---
 rtl/matrix_uart_parser.sv | 87 ++++++++
 tb/tb_matrix_uart_parser.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_uart_parser.sv
// matrix_uart_parser: parses an ASCII "<rows> <cols> <e0> ..." byte stream into a row-major matrix.
module matrix_uart_parser #(
  parameter int MAX_DIM = 5,
  parameter int MAX_VAL = 9,
  parameter int DATA_W  = 8
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                start,
  input  logic [7:0]                          rx_data,
  input  logic                                rx_valid,
  output logic                                busy,
  output logic                                done,
  output logic                                error,
  output logic [1:0]                          err_code,
  output logic [2:0]                          matrix_row,
  output logic [2:0]                          matrix_col,
  output logic [MAX_DIM*MAX_DIM*DATA_W-1:0]   data_flat
);
  localparam logic [2:0] IDLE = 3'd0, GET_ROW = 3'd1, GET_COL = 3'd2, GET_ELEM = 3'd3,
                         FINISH = 3'd4, FAIL = 3'd5;
  logic [2:0]  state;
  logic [11:0] acc, acc_next;
  logic [5:0]  idx, last;
  logic        tok_active, is_digit, is_delim, over;
  assign is_digit = rx_data >= 8'h30 && rx_data <= 8'h39;
  assign is_delim = rx_data == 8'h20 || rx_data == 8'h0A || rx_data == 8'h0D || rx_data == 8'h2C;
  assign acc_next = acc * 12'd10 + {8'd0, rx_data[3:0]};
  assign over     = state == GET_ELEM ? acc_next > 12'(MAX_VAL) : acc_next > 12'(MAX_DIM);
  assign last     = 6'(matrix_row) * 6'(matrix_col) - 6'd1;
  assign busy     = state == GET_ROW || state == GET_COL || state == GET_ELEM;
  assign done     = state == FINISH;
  assign error    = state == FAIL;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      acc        <= '0;
      idx        <= '0;
      tok_active <= 1'b0;
      err_code   <= '0;
      matrix_row <= '0;
      matrix_col <= '0;
      data_flat  <= '0;
    end else if (start) begin
      state      <= GET_ROW;
      acc        <= '0;
      idx        <= '0;
      tok_active <= 1'b0;
      err_code   <= '0;
      matrix_row <= '0;
      matrix_col <= '0;
      data_flat  <= '0;
    end else if (done || error) begin
      state <= IDLE;
    end else if (busy && rx_valid) begin
      if (is_digit) begin
        if (over) begin
          err_code <= state == GET_ELEM ? 2'd2 : 2'd3;
          state    <= FAIL;
        end else begin
          acc        <= acc_next;
          tok_active <= 1'b1;
        end
      end else if (!is_delim) begin
        err_code <= 2'd1;
        state    <= FAIL;
      end else if (tok_active) begin
        acc        <= '0;
        tok_active <= 1'b0;
        if (state != GET_ELEM && acc == 12'd0) begin
          err_code <= 2'd3;
          state    <= FAIL;
        end else if (state == GET_ROW) begin
          matrix_row <= acc[2:0];
          state      <= GET_COL;
        end else if (state == GET_COL) begin
          matrix_col <= acc[2:0];
          state      <= GET_ELEM;
        end else begin
          data_flat[int'(idx)*DATA_W +: DATA_W] <= acc[DATA_W-1:0];
          idx <= idx + 6'd1;
          if (idx == last) state <= FINISH;
        end
      end
    end
  end
endmodule

// File: tb/tb_matrix_uart_parser.sv
// tb_matrix_uart_parser: randomized and directed checks of the parser against a token-level model.
module tb_matrix_uart_parser;
  localparam int N = 25;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic busy, done, error;
  logic [1:0] err_code;
  logic [2:0] matrix_row, matrix_col;
  logic [N*8-1:0] data_flat;
  int pass_cnt = 0, total = 0;

  matrix_uart_parser dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .busy(busy), .done(done), .error(error), .err_code(err_code),
    .matrix_row(matrix_row), .matrix_col(matrix_col), .data_flat(data_flat)
  );

  always #5 clk = ~clk;

  function automatic void model(input string s, output int at, output bit ok, output logic [1:0] code,
                                output int r, output int c, output logic [N*8-1:0] flat);
    int ntok = 0, acc = 0;
    bit active = 0;
    byte ch;
    at = -1; ok = 0; code = 0; r = 0; c = 0; flat = '0;
    for (int i = 0; i < s.len(); i++) begin
      ch = s[i];
      if (ch >= "0" && ch <= "9") begin
        acc = acc * 10 + (ch - 48);
        if (acc > (ntok < 2 ? 5 : 9)) begin
          code = ntok < 2 ? 2'd3 : 2'd2; at = i; return;
        end
        active = 1;
      end else if (ch == " " || ch == 8'h0A || ch == 8'h0D || ch == ",") begin
        if (active) begin
          if (ntok < 2 && acc == 0) begin code = 2'd3; at = i; return; end
          if (ntok == 0) r = acc;
          else if (ntok == 1) c = acc;
          else flat[(ntok-2)*8 +: 8] = 8'(acc);
          ntok++; acc = 0; active = 0;
          if (ntok >= 2 && ntok - 2 == r * c) begin ok = 1; at = i; return; end
        end
      end else begin
        code = 2'd1; at = i; return;
      end
    end
  endfunction

  task automatic do_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic send(input string s);
    for (int i = 0; i < s.len(); i++) begin
      @(negedge clk); rx_data = s[i]; rx_valid = 1'b1;
      @(negedge clk); rx_valid = 1'b0;
    end
  endtask

  task automatic test_stream(input string name, input string s, input bit gaps);
    int e_at, e_r, e_c, got_at;
    bit e_ok, got_done, got_err, stop;
    logic [1:0] e_code;
    logic [N*8-1:0] e_flat;
    model(s, e_at, e_ok, e_code, e_r, e_c, e_flat);
    got_at = -1; got_done = 0; got_err = 0; stop = 0;
    for (int i = 0; i < s.len() && !stop; i++) begin
      @(negedge clk); rx_data = s[i]; rx_valid = 1'b1;
      @(negedge clk); rx_valid = 1'b0;
      if (done || error) begin
        got_at = i; got_done = done; got_err = error; stop = 1;
        @(negedge clk);
        total++;
        if ((done | error) !== 1'b0) $display("FAIL %s pulse_width: done=%b error=%b, required 0 0", name, done, error);
        else pass_cnt++;
      end else if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          @(negedge clk);
          if ((done || error) && !stop) begin got_at = i + 1000; stop = 1; end
        end
      end
    end
    if (!stop) repeat (3) begin
      @(negedge clk);
      if ((done || error) && got_at < 0) got_at = 9999;
    end
    total++;
    if (got_at !== e_at) $display("FAIL %s outcome_index: got %0d, required %0d (\"%s\")", name, got_at, e_at, s);
    else pass_cnt++;
    total++;
    if (got_done !== (e_at >= 0 && e_ok) || got_err !== (e_at >= 0 && !e_ok))
      $display("FAIL %s outcome_kind: done=%b error=%b, required done=%b", name, got_done, got_err, e_ok);
    else pass_cnt++;
    total++;
    if (err_code !== e_code) $display("FAIL %s err_code: got %0d, required %0d", name, err_code, e_code);
    else pass_cnt++;
    total++;
    if (matrix_row !== 3'(e_r) || matrix_col !== 3'(e_c))
      $display("FAIL %s dims: got %0dx%0d, required %0dx%0d", name, matrix_row, matrix_col, e_r, e_c);
    else pass_cnt++;
    total++;
    if (data_flat !== e_flat) $display("FAIL %s data_flat: got %h, required %h", name, data_flat, e_flat);
    else pass_cnt++;
    total++;
    if (busy !== (e_at < 0)) $display("FAIL %s busy_end: got %b, required %b", name, busy, e_at < 0);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if ({busy, done, error, err_code, matrix_row, matrix_col, data_flat} !== '0)
      $display("FAIL reset_state: busy=%b done=%b error=%b code=%0d dims=%0dx%0d, required all 0",
               busy, done, error, err_code, matrix_row, matrix_col);
    else pass_cnt++;
  endtask

  task automatic test_basic();
    do_start();
    total++;
    if (busy !== 1'b1) $display("FAIL armed_busy: got %b, required 1", busy);
    else pass_cnt++;
    test_stream("basic", "2 3 1 2 3 4 5 6\n", 0);
    do_start(); test_stream("delims", "  1,\015\n1  7 ", 1);
  endtask

  task automatic test_errors();
    do_start(); test_stream("illegal", "2 2 1 x", 0);
    do_start(); test_stream("val_overflow", "1 2 4 12 ", 0);
    do_start(); test_stream("dim_big", "6 ", 0);
    do_start(); test_stream("dim_zero", "0 ", 0);
    do_start(); test_stream("no_trailing_delim", "1 1 3", 0);
  endtask

  task automatic test_restart();
    do_start(); send("3 3 1 2");
    do_start();
    total++;
    if (busy !== 1'b1 || matrix_row !== 3'd0 || matrix_col !== 3'd0 || data_flat !== '0)
      $display("FAIL restart_clear: busy=%b dims=%0dx%0d data=%h, required busy 1 and zeros",
               busy, matrix_row, matrix_col, data_flat);
    else pass_cnt++;
    test_stream("restart", "1 1 5 ", 1);
  endtask

  task automatic test_start_collision();
    do_start(); send("2 ");
    @(negedge clk); start = 1'b1; rx_valid = 1'b1; rx_data = "3";
    @(negedge clk); start = 1'b0; rx_valid = 1'b0;
    test_stream("collision", " 1 1 4 ", 0);
  endtask

  task automatic test_idle_ignore();
    do_start(); test_stream("pre_idle", "1 1 5 ", 0);
    send("2 2 1 2 3 4 ");
    total++;
    if (busy !== 1'b0 || matrix_row !== 3'd1 || matrix_col !== 3'd1 || data_flat !== (N*8)'(8'd5))
      $display("FAIL idle_ignore: busy=%b dims=%0dx%0d data=%h, required 0 1x1 5", busy, matrix_row, matrix_col, data_flat);
    else pass_cnt++;
  endtask

  task automatic test_async_reset();
    do_start(); send("2 2 3");
    @(negedge clk); #2 rst_n = 1'b0;
    #1;
    total++;
    if ({busy, done, error, err_code, matrix_row, matrix_col, data_flat} !== '0)
      $display("FAIL async_reset: busy=%b dims=%0dx%0d data=%h, required all 0", busy, matrix_row, matrix_col, data_flat);
    else pass_cnt++;
    @(negedge clk); rst_n = 1'b1;
    send("1 1 1 ");
    total++;
    if (busy !== 1'b0 || matrix_row !== 3'd0 || data_flat !== '0)
      $display("FAIL post_reset_idle: busy=%b row=%0d, required 0 0", busy, matrix_row);
    else pass_cnt++;
  endtask

  task automatic test_random();
    string dl = " \n\015,";
    string s;
    int r, c, fault;
    for (int t = 0; t < 40; t++) begin
      r = $urandom_range(0, 6); c = $urandom_range(1, 5);
      if ($urandom_range(0, 3) != 0 && r == 0) r = 1;
      if (r == 6 && $urandom_range(0, 1) != 0) r = 5;
      fault = $urandom_range(0, 7);
      s = ($urandom_range(0, 2) == 0) ? "," : "";
      s = $sformatf("%s%0d%c%0d%c", s, r, dl[$urandom_range(0, 3)], c, dl[$urandom_range(0, 3)]);
      for (int k = 0; k < r * c; k++) begin
        if (fault == 1 && k == r * c - 1) s = $sformatf("%s%0d", s, $urandom_range(10, 40));
        else if (fault == 2 && k == 0) s = $sformatf("%s%c", s, byte'($urandom_range(97, 122)));
        else s = $sformatf("%s%0d", s, $urandom_range(0, 9));
        s = $sformatf("%s%c", s, dl[$urandom_range(0, 3)]);
        if ($urandom_range(0, 4) == 0) s = $sformatf("%s%c", s, dl[$urandom_range(0, 3)]);
      end
      do_start();
      test_stream($sformatf("rand%0d", t), s, 1);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_errors();
    test_restart();
    test_start_collision();
    test_idle_ignore();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end
endmodule
